// File: rtl/vfd_pkg.sv
// Shared types and constants for the VFD grid-refresh scheduler.
//   - vfd_state_e : refresh FSM states
//   - GCP_COUNT / GCP_THRESH : bit indices inside the shift window where GCP fires
//   - NUM_GRIDS_DEF / SHIFT_BITS_DEF : default geometry of the MN15439A panel
package vfd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBlank,
    StLatch,
    StUnblank,
    StShift,
    StHold
  } vfd_state_e;

  localparam int unsigned NUM_GRIDS_DEF  = 52;
  localparam int unsigned SHIFT_BITS_DEF = 288;

  localparam int unsigned GCP_COUNT = 6;
  // Grayscale slice boundaries, in ascending order so dimming keeps the first N.
  localparam logic [8:0] GCP_THRESH [GCP_COUNT] = '{
    9'd72, 9'd144, 9'd192, 9'd216, 9'd240, 9'd256
  };

endpackage

// File: rtl/vfd_gcp_gen.sv
// Gradient control pulse generator.
// Fires a one-cycle GCP whenever the shift window reaches one of the grayscale
// thresholds. With VFD_DIM_EN defined, only the first bright_i thresholds fire.
// Ports:
//   bit_idx_i  : current serial bit index
//   shift_en_i : high while the serializer is shifting
//   bright_i   : brightness level, 0..7 (only with VFD_DIM_EN)
//   gcp_o      : gradient control pulse
module vfd_gcp_gen
  import vfd_pkg::*;
(
  input  logic [8:0] bit_idx_i,
  input  logic       shift_en_i,
`ifdef VFD_DIM_EN
  input  logic [2:0] bright_i,
`endif
  output logic       gcp_o
);

  int unsigned lim;

  always_comb begin
`ifdef VFD_DIM_EN
    // Levels 6 and 7 both enable every threshold.
    lim = int'(bright_i);
`else
    lim = GCP_COUNT;
`endif
    gcp_o = 1'b0;
    for (int unsigned k = 0; k < GCP_COUNT; k++) begin
      if (shift_en_i && (bit_idx_i == GCP_THRESH[k]) && (k < lim)) begin
        gcp_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vfd_refresh_sched.sv
// Grid-refresh scheduler for the MN15439A VFD path.
// Sequences one grid period (BLANK, LATCH, UNBLANK, SHIFT, HOLD), steps the grid
// number, emits GCP pulses and swaps the displayed GRAM bank only at frame
// boundaries. Optional dimming is compiled in with the VFD_DIM_EN macro.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   en_i            : refresh enable, sampled only at a period boundary
//   swap_req_i      : host finished the back bank (one-cycle pulse)
//   bright_i        : brightness 0..7 (only with VFD_DIM_EN)
//   swap_ack_o      : pulse when bank_sel_o toggles
//   bank_sel_o      : GRAM bank currently displayed
//   blk_o, lat_o    : display blanking, serial latch
//   shift_en_o      : gates the Tri-SPI clock
//   bit_idx_o       : serial bit index while shifting, else 0
//   grid_num_o      : grid being loaded in this period
//   gcp_o           : gradient control pulse
//   frame_start_o   : pulse when the grid number wraps to 0
module vfd_refresh_sched
  import vfd_pkg::*;
#(
  parameter int unsigned CLK_PER_GRID = 3840,
  parameter int unsigned NUM_GRIDS    = NUM_GRIDS_DEF,
  parameter int unsigned SHIFT_BITS   = SHIFT_BITS_DEF,
  parameter int unsigned LAT_LEN      = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       swap_req_i,
`ifdef VFD_DIM_EN
  input  logic [2:0] bright_i,
`endif
  output logic       swap_ack_o,
  output logic       bank_sel_o,
  output logic       blk_o,
  output logic       lat_o,
  output logic       shift_en_o,
  output logic [8:0] bit_idx_o,
  output logic [5:0] grid_num_o,
  output logic       gcp_o,
  output logic       frame_start_o
);

  localparam int unsigned CntW       = $clog2(CLK_PER_GRID);
  localparam int unsigned ShiftStart = LAT_LEN + 2;
  localparam int unsigned ShiftEnd   = LAT_LEN + 1 + SHIFT_BITS;

  if (CLK_PER_GRID < LAT_LEN + SHIFT_BITS + 3) begin : g_bad_period
    $fatal(1, "vfd_refresh_sched: CLK_PER_GRID too short for LAT_LEN + SHIFT_BITS + 3");
  end

  vfd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      grid_q, grid_d;
  logic            bank_q, bank_d;
  logic            pend_q, pend_d;
  logic            last_cnt;
  logic            enter_blank;
  logic            frame_start;
  logic            swap_ack;

  assign last_cnt = (cnt_q == CntW'(CLK_PER_GRID - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grid_d      = grid_q;
    enter_blank = 1'b0;
    if (state_q != StIdle) begin
      cnt_d = last_cnt ? '0 : cnt_q + CntW'(1);
    end
    unique case (state_q)
      StIdle: begin
        // Resume on the held grid number; no increment.
        if (en_i) begin
          state_d     = StBlank;
          enter_blank = 1'b1;
        end
      end
      StBlank:   state_d = StLatch;
      StLatch:   if (cnt_q == CntW'(LAT_LEN)) state_d = StUnblank;
      StUnblank: state_d = StShift;
      StShift:   if (cnt_q == CntW'(ShiftEnd)) state_d = StHold;
      StHold: begin
        if (last_cnt) begin
          if (en_i) begin
            state_d     = StBlank;
            enter_blank = 1'b1;
            grid_d      = (grid_q == 6'(NUM_GRIDS - 1)) ? '0 : grid_q + 6'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The boundary cycle is the BLANK of grid 0; a request arriving in that very
  // cycle still swaps, so the ack path is combinational from swap_req_i.
  assign frame_start = (state_q == StBlank) && (grid_q == '0);
  assign swap_ack    = frame_start && (pend_q || swap_req_i);
  assign pend_d      = (pend_q || swap_req_i) && !swap_ack;
  assign bank_d      = bank_q ^ swap_ack;

`ifdef VFD_DIM_EN
  logic [2:0] bright_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bright_q <= '0;
    end else if (enter_blank) begin
      bright_q <= bright_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grid_q  <= '0;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grid_q  <= grid_d;
      bank_q  <= bank_d;
      pend_q  <= pend_d;
    end
  end

  assign blk_o         = (state_q == StBlank) || (state_q == StLatch) || (state_q == StUnblank);
  assign lat_o         = (state_q == StLatch);
  assign shift_en_o    = (state_q == StShift);
  assign bit_idx_o     = shift_en_o ? 9'(cnt_q - CntW'(ShiftStart)) : '0;
  assign grid_num_o    = grid_q;
  assign frame_start_o = frame_start;
  assign swap_ack_o    = swap_ack;
  assign bank_sel_o    = bank_q ^ swap_ack;

  vfd_gcp_gen u_gcp_gen (
    .bit_idx_i  (bit_idx_o),
    .shift_en_i (shift_en_o),
`ifdef VFD_DIM_EN
    .bright_i   (bright_q),
`endif
    .gcp_o      (gcp_o)
  );

endmodule

// File: tb/tb_vfd_refresh_sched.sv
// Directed self-checking bench for vfd_refresh_sched.
// Two instances share a clock and reset: a default-geometry one (3840 clocks,
// 52 grids) and a small one (300 clocks, 4 grids) for frame/swap timing.
// Build with VFD_DIM_EN defined to exercise the dimming path.
module tb_vfd_refresh_sched;

  localparam int unsigned Cpg      = 3840;
  localparam int unsigned SmallCpg = 300;
  localparam int unsigned SmallNg  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, swap_req, en_s, swap_req_s;
  logic       swap_ack, bank_sel, blk, lat, shift_en, gcp, frame_start;
  logic [8:0] bit_idx;
  logic [5:0] grid_num;
  logic       swap_ack_s, bank_sel_s, blk_s, lat_s, shift_en_s, gcp_s, frame_start_s;
  logic [8:0] bit_idx_s;
  logic [5:0] grid_num_s;
`ifdef VFD_DIM_EN
  logic [2:0] bright;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned gcp_at [6] = '{72, 144, 192, 216, 240, 256};

  vfd_refresh_sched dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .swap_req_i    (swap_req),
`ifdef VFD_DIM_EN
    .bright_i      (bright),
`endif
    .swap_ack_o    (swap_ack),
    .bank_sel_o    (bank_sel),
    .blk_o         (blk),
    .lat_o         (lat),
    .shift_en_o    (shift_en),
    .bit_idx_o     (bit_idx),
    .grid_num_o    (grid_num),
    .gcp_o         (gcp),
    .frame_start_o (frame_start)
  );

  vfd_refresh_sched #(
    .CLK_PER_GRID (SmallCpg),
    .NUM_GRIDS    (SmallNg)
  ) dut_s (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en_s),
    .swap_req_i    (swap_req_s),
`ifdef VFD_DIM_EN
    .bright_i      (bright),
`endif
    .swap_ack_o    (swap_ack_s),
    .bank_sel_o    (bank_sel_s),
    .blk_o         (blk_s),
    .lat_o         (lat_s),
    .shift_en_o    (shift_en_s),
    .bit_idx_o     (bit_idx_s),
    .grid_num_o    (grid_num_s),
    .gcp_o         (gcp_s),
    .frame_start_o (frame_start_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at the observation point of cycle 0 (first BLANK of a period);
  // leaves at the observation point of cycle Cpg.
  task automatic period_scan(input string tag, input int unsigned gcp_lim, input bit with_small);
    int unsigned e_blk = 0, e_lat = 0, e_sh = 0, e_idx = 0, e_gcp = 0;
    int unsigned n_sh = 0, n_gcp = 0;
    int unsigned e_fs = 0, e_ack = 0, e_bank = 0, e_grid = 0;
    for (int unsigned c = 0; c < Cpg; c++) begin
      logic x_blk, x_lat, x_sh, x_gcp;
      int unsigned x_idx;
      if (with_small) begin
        swap_req_s = (c == 350) || (c == 400) || (c == 1201) || (c == 3600);
      end
      #1;
      x_blk = (c <= 6);
      x_lat = (c >= 1) && (c <= 5);
      x_sh  = (c >= 7) && (c <= 294);
      x_idx = x_sh ? c - 7 : 0;
      x_gcp = 1'b0;
      for (int unsigned k = 0; k < 6; k++) begin
        if (x_sh && (x_idx == gcp_at[k]) && (k < gcp_lim)) x_gcp = 1'b1;
      end
      if (blk !== x_blk) e_blk++;
      if (lat !== x_lat) e_lat++;
      if (shift_en !== x_sh) e_sh++;
      if (bit_idx !== 9'(x_idx)) e_idx++;
      if (gcp !== x_gcp) e_gcp++;
      if (shift_en === 1'b1) n_sh++;
      if (gcp === 1'b1) n_gcp++;
      if (with_small) begin
        int unsigned cs, fr;
        cs = c % SmallCpg;
        fr = (c / SmallCpg) % SmallNg;
        if (cs == 0 && c <= 1200) check($sformatf("grid_seq_%0d", c), grid_num_s, fr);
        if (grid_num_s !== 6'(fr)) e_grid++;
        if (frame_start_s !== ((cs == 0) && (fr == 0))) e_fs++;
        if (swap_ack_s !== ((c == 1200) || (c == 2400) || (c == 3600))) e_ack++;
        if (bank_sel_s !== (((c >= 1200) && (c < 2400)) || (c >= 3600))) e_bank++;
      end
      @(posedge clk);
      #1;
    end
    swap_req_s = 1'b0;
    check({tag, "_blk_errs"}, e_blk, 0);
    check({tag, "_lat_errs"}, e_lat, 0);
    check({tag, "_shift_errs"}, e_sh, 0);
    check({tag, "_bitidx_errs"}, e_idx, 0);
    check({tag, "_gcp_errs"}, e_gcp, 0);
    check({tag, "_shift_cycles"}, n_sh, 288);
    check({tag, "_gcp_pulses"}, n_gcp, gcp_lim);
    check({tag, "_next_blk"}, blk, 1);
    check({tag, "_next_grid"}, grid_num, 1);
    if (with_small) begin
      check("small_grid_errs", e_grid, 0);
      check("small_frame_start_errs", e_fs, 0);
      check("small_swap_ack_errs", e_ack, 0);
      check("small_bank_sel_errs", e_bank, 0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    en_s       = 1'b0;
    swap_req   = 1'b0;
    swap_req_s = 1'b0;
`ifdef VFD_DIM_EN
    bright     = 3'd7;
`endif
    repeat (3) step();
    check("reset_outs", {swap_ack, bank_sel, blk, lat, shift_en, bit_idx, grid_num, gcp,
                         frame_start}, 0);
    check("reset_outs_s", {swap_ack_s, bank_sel_s, blk_s, lat_s, shift_en_s, bit_idx_s,
                           grid_num_s, gcp_s, frame_start_s}, 0);
    rst_n = 1'b1;
    step();
    check("idle_no_en", {blk, lat, shift_en}, 0);

    en   = 1'b1;
    en_s = 1'b1;
    step();
    check("c0_frame_start", frame_start, 1);
    check("c0_grid", grid_num, 0);
    period_scan("p0", 6, 1'b1);

    // Drop EN at counter 100 of grid 1; the period must still complete.
    repeat (100) step();
    en = 1'b0;
    repeat (3739) step();
    check("endrop_hold_last", {blk, shift_en}, 0);
    step();
    check("endrop_idle_blk", blk, 0);
    check("endrop_idle_grid", grid_num, 1);
    repeat (5) step();
    check("endrop_idle_still", {blk, lat, shift_en, gcp}, 0);
    en = 1'b1;
    step();
    check("resume_blk", blk, 1);
    check("resume_grid", grid_num, 1);
    check("resume_no_frame_start", frame_start, 0);

    step();
    step();
    check("mid_latch_lat", lat, 1);
    rst_n = 1'b0;
    step();
    check("rst_lat", lat, 0);
    check("rst_blk", blk, 0);
    check("rst_grid", grid_num, 0);
    check("rst_bank_s", bank_sel_s, 0);

    en_s = 1'b0;
`ifdef VFD_DIM_EN
    bright = 3'd2;
`endif
    rst_n = 1'b1;
    step();
    check("rerun_frame_start", frame_start, 1);
`ifdef VFD_DIM_EN
    period_scan("dim2", 2, 1'b0);
`else
    period_scan("p_rerun", 6, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vfd_refresh_sched.md
Name: vfd_refresh_sched

Overview:
- Grid-refresh scheduler for the MN15439A VFD path. Owns one grid period at a time and drives BLK and LAT, the Tri-SPI shift enable and bit index, the grid number and the GCP grayscale pulses.
- Also arbitrates host frame-buffer swaps: the host side can request a GRAM bank swap, and the swap takes effect only at a frame boundary, so a frame never tears.
- Sits between top-level timing and the Tri-SPI serializer / GRAM read port. Replaces the free-running counters and #-delay pulse code.

Parameters:
- CLK_PER_GRID, 3840: clocks per grid period (12 MHz / (60 fps × 52 grids) ≈ 3840).
- NUM_GRIDS, 52: grid count. GRID_NUM wraps NUM_GRIDS-1 → 0.
- SHIFT_BITS, 288: serial bits per grid (234 pixel + grid bits).
- LAT_LEN, 5: LAT high time in clocks.

Ports:
- CLK  in  1  system clock (12 MHz).
- RST_N  in  1  synchronous reset, active low.
- EN  in  1  refresh enable; sampled only at a period boundary.
- SWAP_REQ  in  1  one-cycle pulse: host finished writing the back bank.
- SWAP_ACK  out  1  one-cycle pulse when BANK_SEL toggles.
- BANK_SEL  out  1  GRAM bank currently displayed.
- BLK  out  1  display blanking.
- LAT  out  1  serial latch.
- SHIFT_EN  out  1  gates the Tri-SPI clock; high for exactly SHIFT_BITS cycles per period.
- BIT_IDX  out  9  current bit index (0..SHIFT_BITS-1) while SHIFT_EN=1, else 0.
- GRID_NUM  out  6  grid being loaded in this period.
- GCP  out  1  gradient control pulse, one cycle wide.
- FRAME_START  out  1  one-cycle pulse when GRID_NUM wraps to 0.

Behaviour:
- Reset (RST_N=0 at posedge):
  - state IDLE.
  - Period counter, GRID_NUM, BANK_SEL, swap-pending flag all cleared to 0.
  - Every output = 0.
- Period counter: 0..CLK_PER_GRID-1, runs whenever state≠IDLE. Count 0 is the period boundary.
- Elaboration check: CLK_PER_GRID ≥ LAT_LEN+SHIFT_BITS+3. A violation is a fatal elaboration error.
- FSM states: IDLE, BLANK, LATCH, UNBLANK, SHIFT, HOLD.
  - IDLE: EN=1 → BLANK, counter=0. All outputs low, BANK_SEL held.
  - BLANK: 1 cycle, BLK=1 → LATCH.
  - LATCH: LAT_LEN cycles, BLK=1, LAT=1 → UNBLANK.
  - UNBLANK: 1 cycle, BLK=1, LAT=0 → SHIFT.
  - SHIFT: SHIFT_BITS cycles, SHIFT_EN=1, BIT_IDX counts 0..SHIFT_BITS-1 → HOLD.
  - HOLD: until counter = CLK_PER_GRID-1, then branch on EN:
    - EN=1 → BLANK.
    - EN=0 → IDLE.
- Entering BLANK from HOLD: GRID_NUM += 1, wrapping NUM_GRIDS-1 → 0. The first BLANK after IDLE keeps the current GRID_NUM.
- GCP: pulses for exactly one cycle while in SHIFT when BIT_IDX ∈ {72,144,192,216,240,256}. Indices ≥ SHIFT_BITS never fire.
- Frame boundary = the cycle GRID_NUM wraps to 0 (including the first BLANK after reset). On that cycle FRAME_START=1.
- Swap arbitration:
  - SWAP_REQ sets the pending flag.
  - At a frame boundary with the flag set (or SWAP_REQ=1 in that same cycle): BANK_SEL toggles, SWAP_ACK=1 for 1 cycle, flag clears.
  - Repeat requests before the boundary collapse into one swap.
  - SWAP_REQ in the cycle after the boundary waits a full frame.
- EN dropping mid-period: the period completes normally; the block goes IDLE at the boundary. GRID_NUM and BANK_SEL are held; a pending swap is retained.
- Reset mid-period: all outputs low on the next cycle, no partial LAT or GCP.

Optional Feature:
- Macro VFD_DIM_EN.
- Defined: adds input BRIGHT[2:0]. Only the first min(BRIGHT,6) GCP pulses of each period are emitted; BRIGHT=0 emits none. BRIGHT is sampled at BLANK entry and held for the period.
- Undefined: BRIGHT port is absent; all 6 pulses are emitted.

Decomposition:
- Package vfd_pkg holds:
  - state enum.
  - GCP threshold array {72,144,192,216,240,256} and GCP_COUNT=6.
  - Defaults for NUM_GRIDS and SHIFT_BITS.
- One natural sub-module, vfd_gcp_gen: takes BIT_IDX and SHIFT_EN (and BRIGHT when VFD_DIM_EN is defined), outputs GCP.

Test Plan:
- Reset, then EN=1 with defaults:
  - BLK high cycles 0–6.
  - LAT high cycles 1–5.
  - SHIFT_EN high cycles 7–294, exactly 288 cycles.
  - Next BLK at cycle 3840.
- GCP check: exactly 6 pulses per period, at SHIFT cycle offsets 72,144,192,216,240,256. No pulse outside SHIFT.
- NUM_GRIDS=4, CLK_PER_GRID=300: GRID_NUM sequence 0,1,2,3,0. FRAME_START at GRID_NUM 0 entries, at cycles 0 and 1200.
- Swap timing: SWAP_REQ at grid 1, twice → single SWAP_ACK at the next wrap, BANK_SEL 0→1. SWAP_REQ coincident with the wrap cycle → toggles in that same cycle.
- EN drop: EN=0 at counter 100 → period finishes, IDLE at 3840, GRID_NUM held. EN=1 → resumes the same GRID_NUM.
- Reset and dimming: RST_N=0 mid-LATCH → LAT=0 next cycle, GRID_NUM=0, BANK_SEL=0. With VFD_DIM_EN and BRIGHT=2 → only pulses at 72 and 144.
